// File: rtl/alu_rr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the round-robin ALU sequencer:
//                opcode encodings, sequencer FSM states, default width and
//                a small opcode-class helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DEFAULT_DATA_W = 9;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Shifts are the only ops that take more than one ALU step.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_sequencer_if
//  Description : Request/response bundle between NREQ requesters and the
//                ALU sequencer.
//                master : requester/consumer side (drives req_*, rsp_ready)
//                slave  : sequencer side (drives req_ready, rsp_*)
//                Requester i occupies slice [i*W +: W] of each packed field.
//                With ALU_FLAGS_EN defined, rsp_zero and rsp_carry are added.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_rr_sequencer_if
    import alu_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int NREQ    = 2,
    parameter int SHAMT_W = 4,
    parameter int ID_W    = 1
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*DATA_W-1:0]  req_a;
    logic [NREQ*DATA_W-1:0]  req_b;
    logic [NREQ*3-1:0]       req_op;
    logic [NREQ*SHAMT_W-1:0] req_shamt;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_result;
`ifdef ALU_FLAGS_EN
    logic                    rsp_zero;
    logic                    rsp_carry;
`endif

    modport master (
        output req_valid, req_a, req_b, req_op, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
`ifdef ALU_FLAGS_EN
        , input rsp_zero, rsp_carry
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
`ifdef ALU_FLAGS_EN
        , output rsp_zero, rsp_carry
`endif
    );

endinterface
`default_nettype wire

// File: rtl/alu_rr_sequencer_alu_step.sv
`default_nettype none
// ============================================================================
//  Module      : alu_step
//  Description : Combinational single-step ALU. Shifts move by exactly one
//                bit; multi-bit shifts are sequenced by the caller.
//  Ports       : a, b    - operands (DATA_W)
//                op      - opcode (3)
//                result  - step result (DATA_W)
//                carry   - carry / not-borrow / shifted-out bit
//                          (present only with ALU_FLAGS_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_step
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    input  wire logic [2:0]        op,
    output logic      [DATA_W-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic                   carry
`endif
);

    // The extra top bit carries the flag when flags are built in; without
    // flags it is simply not generated, so no dead logic remains.
`ifdef ALU_FLAGS_EN
    localparam int FW = DATA_W + 1;
`else
    localparam int FW = DATA_W;
`endif

    logic [FW-1:0] w_full;

    always_comb begin
        w_full = '0;
        case (op)
            ALU_ADD: w_full = FW'(a) + FW'(b);
            ALU_SUB: w_full = FW'(a) + FW'(~b) + FW'(1);
            ALU_AND: w_full = FW'(a & b);
            ALU_OR:  w_full = FW'(a | b);
            ALU_XOR: w_full = FW'(a ^ b);
            // Bit shifted out lands in the top (carry) position.
            ALU_SHL: w_full = FW'({a, 1'b0});
            ALU_SHR: w_full = FW'({a[0], 1'b0, a[DATA_W-1:1]});
            ALU_NOT: w_full = FW'(~a);
        endcase
    end

    assign result = w_full[DATA_W-1:0];
`ifdef ALU_FLAGS_EN
    assign carry  = w_full[FW-1];
`endif

endmodule
`default_nettype wire

// File: rtl/alu_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_sequencer
//  Description : Shares one ALU step datapath among NREQ requesters with
//                round-robin arbitration. Multi-bit shifts run as repeated
//                1-bit steps. Each result returns on a single response
//                channel tagged with the requester index.
//                Optional macro ALU_FLAGS_EN adds rsp_zero / rsp_carry.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - alu_rr_sequencer_if.slave (requests + response)
//                busy  - high whenever the FSM is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int NREQ    = 2,
    parameter int SHAMT_W = 4,
    parameter int ID_W    = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_rr_sequencer_if.slave bus,
    output logic              busy
);

    state_t              r_state;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_b;
    logic [2:0]          r_op;
    logic [SHAMT_W-1:0]  r_cnt;
    logic                r_hold;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_result;
`ifdef ALU_FLAGS_EN
    logic                r_rsp_zero;
    logic                r_rsp_carry;
    logic                w_step_carry;
    logic                w_next_carry;
`endif

    logic                w_gnt_valid;
    logic [ID_W-1:0]     w_gnt_idx;
    logic [NREQ-1:0]     w_ready;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [2:0]          w_sel_op;
    logic [SHAMT_W-1:0]  w_sel_shamt;
    logic                w_sel_shift;
    logic [DATA_W-1:0]   w_step_res;
    logic [DATA_W-1:0]   w_next_acc;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester after the last one served.
    // ------------------------------------------------------------------
    always_comb begin
        int v_j;
        v_j         = 0;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            v_j = int'(r_last) + i;
            if (v_j >= NREQ) begin
                v_j = v_j - NREQ;
            end
            if (!w_gnt_valid && bus.req_valid[v_j]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = ID_W'(v_j);
            end
        end
    end

    // Ready only in IDLE and never while reset is asserted (the FSM sits in
    // IDLE during reset, so the reset term must gate it explicitly).
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = rst_n && (r_state == IDLE) && w_gnt_valid &&
                         (w_gnt_idx == ID_W'(i));
        end
    end

    assign w_sel_a     = bus.req_a[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_sel_b     = bus.req_b[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_sel_op    = bus.req_op[int'(w_gnt_idx)*3 +: 3];
    assign w_sel_shamt = bus.req_shamt[int'(w_gnt_idx)*SHAMT_W +: SHAMT_W];
    assign w_sel_shift = is_shift(w_sel_op);

    // ------------------------------------------------------------------
    // Single ALU step. The accumulator starts at operand A, so one step
    // of a non-shift op yields op(a, b) and shifts iterate on acc.
    // ------------------------------------------------------------------
    alu_step #(
        .DATA_W (DATA_W)
    ) u_alu_step (
        .a      (r_acc),
        .b      (r_b),
        .op     (r_op),
        .result (w_step_res)
`ifdef ALU_FLAGS_EN
        ,
        .carry  (w_step_carry)
`endif
    );

    // A zero-amount shift spends its single EXEC cycle holding acc.
    assign w_next_acc   = r_hold ? r_acc : w_step_res;
`ifdef ALU_FLAGS_EN
    assign w_next_carry = r_hold ? 1'b0 : w_step_carry;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last       <= ID_W'(NREQ - 1);
            r_id         <= '0;
            r_acc        <= '0;
            r_b          <= '0;
            r_op         <= ALU_ADD;
            r_cnt        <= '0;
            r_hold       <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
`ifdef ALU_FLAGS_EN
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_acc   <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_id    <= w_gnt_idx;
                        r_last  <= w_gnt_idx;
                        r_hold  <= w_sel_shift && (w_sel_shamt == '0);
                        r_cnt   <= (w_sel_shift && (w_sel_shamt != '0)) ?
                                   w_sel_shamt : SHAMT_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_acc <= w_next_acc;
                    r_cnt <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_id;
                        r_rsp_result <= w_next_acc;
`ifdef ALU_FLAGS_EN
                        r_rsp_zero   <= (w_next_acc == '0);
                        r_rsp_carry  <= w_next_carry;
`endif
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
`ifdef ALU_FLAGS_EN
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_carry  = r_rsp_carry;
`endif
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rr_sequencer
//  Description : Self-checking bench for alu_rr_sequencer (NREQ=2, 9-bit).
//                Directed vector table, randomized transactions against an
//                arithmetic reference model, and hand-written sequences for
//                contention, response backpressure and reset mid-shift.
//                Flag checks are compiled in with ALU_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sequencer;

    localparam int DW = 9;
    localparam int NR = 2;
    localparam int SW = 4;
    localparam int IW = 1;

    logic clk;
    logic rst_n;
    logic busy;

    int n_tests;
    int n_fail;

    alu_rr_sequencer_if #(.DATA_W(DW), .NREQ(NR), .SHAMT_W(SW), .ID_W(IW)) bus ();

    alu_rr_sequencer #(
        .DATA_W  (DW),
        .NREQ    (NR),
        .SHAMT_W (SW),
        .ID_W    (IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         rid;
        logic [2:0] op;
        logic [8:0] a;
        logic [8:0] b;
        logic [3:0] sh;
        logic [8:0] res;
        int         lat;
        logic       cy;
        logic       zf;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: result and carry straight from the opcode rules.
    function automatic logic [9:0] model(input logic [2:0] op, input logic [8:0] a,
                                         input logic [8:0] b, input logic [3:0] sh);
        int ai, bi, s, r, c;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        c  = 0;
        case (op)
            3'd0: begin s = ai + bi; r = s % 512; c = (s >= 512) ? 1 : 0; end
            3'd1: begin r = (ai - bi + 512) % 512; c = (ai >= bi) ? 1 : 0; end
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            3'd5: begin
                if (sh == 0) r = ai;
                else begin
                    r = (ai << sh) % 512;
                    c = (sh <= 9) ? ((ai >> (9 - int'(sh))) & 1) : 0;
                end
            end
            3'd6: begin
                r = ai >> sh;
                c = (sh == 0) ? 0 : ((ai >> (int'(sh) - 1)) & 1);
            end
            default: r = (~ai) & 511;
        endcase
        return {c[0], r[8:0]};
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [3:0] sh);
        if ((op == 3'd5 || op == 3'd6) && sh > 1) return 1 + int'(sh);
        return 2;
    endfunction

    task automatic set_req(input int r, input logic [2:0] op, input logic [8:0] a,
                           input logic [8:0] b, input logic [3:0] sh);
        bus.req_a[r*DW +: DW]     = a;
        bus.req_b[r*DW +: DW]     = b;
        bus.req_op[r*3 +: 3]      = op;
        bus.req_shamt[r*SW +: SW] = sh;
        bus.req_valid[r]          = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Wait (bounded) for rsp_valid; lat counts negedges after the grant cycle.
    task automatic wait_rsp(output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = c;
                got = 1'b1;
                break;
            end
        end
    endtask

    // One transaction from requester r with rsp_ready held high.
    task automatic txn(input string nm, input int r, input logic [2:0] op,
                       input logic [8:0] a, input logic [8:0] b, input logic [3:0] sh,
                       input logic [8:0] e_res, input int e_lat,
                       input logic e_cy, input logic e_zf);
        bit got;
        int lat;
        @(posedge clk); #1;
        set_req(r, op, a, b, sh);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin
                got = 1'b1;
                break;
            end
        end
        check({nm, "_grant"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_rsp(lat, got);
        check({nm, "_rsp_seen"}, 32'(got), 32'd1);
        check({nm, "_result"}, 32'(bus.rsp_result), 32'(e_res));
        check({nm, "_id"}, 32'(bus.rsp_id), 32'(r));
        check({nm, "_latency"}, 32'(lat), 32'(e_lat));
`ifdef ALU_FLAGS_EN
        check({nm, "_carry"}, 32'(bus.rsp_carry), 32'(e_cy));
        check({nm, "_zero"}, 32'(bus.rsp_zero), 32'(e_zf));
`else
        if (e_cy === 1'bx || e_zf === 1'bx) $display("note: undefined flag expectation");
`endif
    endtask

    initial begin
        bit          got;
        bit          multi;
        int          lat;
        int          gq[$];
        int          iq[$];
        logic [8:0]  rq[$];
        logic [9:0]  m;
        logic [2:0]  op;
        logic [3:0]  sh;
        logic [8:0]  a, b;
        int          r;

        n_tests = 0;
        n_fail  = 0;

        //            rid op      a       b       sh   res     lat cy    zf
        vecs[0]  = '{0, 3'd0, 9'h0FF, 9'h001, 4'd0, 9'h100, 2,  1'b0, 1'b0};
        vecs[1]  = '{1, 3'd1, 9'h003, 9'h005, 4'd0, 9'h1FE, 2,  1'b0, 1'b0};
        vecs[2]  = '{0, 3'd1, 9'h007, 9'h007, 4'd0, 9'h000, 2,  1'b1, 1'b1};
        vecs[3]  = '{0, 3'd5, 9'h003, 9'h000, 4'd4, 9'h030, 5,  1'b0, 1'b0};
        vecs[4]  = '{1, 3'd6, 9'h101, 9'h000, 4'd1, 9'h080, 2,  1'b1, 1'b0};
        vecs[5]  = '{0, 3'd5, 9'h0A5, 9'h000, 4'd0, 9'h0A5, 2,  1'b0, 1'b0};
        vecs[6]  = '{1, 3'd2, 9'h1F0, 9'h0FF, 4'd3, 9'h0F0, 2,  1'b0, 1'b0};
        vecs[7]  = '{0, 3'd3, 9'h100, 9'h001, 4'd0, 9'h101, 2,  1'b0, 1'b0};
        vecs[8]  = '{1, 3'd4, 9'h1FF, 9'h0F0, 4'd0, 9'h10F, 2,  1'b0, 1'b0};
        vecs[9]  = '{0, 3'd7, 9'h0F0, 9'h1FF, 4'd0, 9'h10F, 2,  1'b0, 1'b0};
        vecs[10] = '{1, 3'd0, 9'h1FF, 9'h001, 4'd0, 9'h000, 2,  1'b1, 1'b1};
        vecs[11] = '{0, 3'd6, 9'h1FF, 9'h000, 4'd9, 9'h000, 10, 1'b1, 1'b1};
        vecs[12] = '{1, 3'd5, 9'h001, 9'h000, 4'd15, 9'h000, 16, 1'b0, 1'b1};

        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.req_shamt  = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state, with requests already pending.
        set_req(0, 3'd0, 9'h001, 9'h001, 4'd0);
        set_req(1, 3'd0, 9'h002, 9'h002, 4'd0);
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        bus.req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 13; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].rid, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].sh, vecs[i].res, vecs[i].lat, vecs[i].cy, vecs[i].zf);
        end

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = 9'($urandom_range(0, 511));
            b  = 9'($urandom_range(0, 511));
            sh = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            m  = model(op, a, b, sh);
            txn($sformatf("rnd%0d", i), r, op, a, b, sh, m[8:0], model_lat(op, sh),
                m[9], (m[8:0] == 9'd0));
        end

        // Contention: both requesters valid continuously after reset.
        do_reset();
        set_req(0, 3'd0, 9'h010, 9'h001, 4'd0);
        set_req(1, 3'd1, 9'h020, 9'h002, 4'd0);
        multi = 1'b0;
        for (int c = 0; c < 60 && iq.size() < 4; c++) begin
            @(negedge clk);
            if ($countones(bus.req_ready) > 1) multi = 1'b1;
            if (bus.req_ready[0]) gq.push_back(0);
            if (bus.req_ready[1]) gq.push_back(1);
            if (bus.rsp_valid) begin
                iq.push_back(int'(bus.rsp_id));
                rq.push_back(bus.rsp_result);
            end
        end
        @(posedge clk); #1 bus.req_valid = '0;
        check("cont_rsp_count", 32'(iq.size()), 32'd4);
        check("cont_onehot", 32'(multi), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_grant%0d", i), (i < gq.size()) ? 32'(gq[i]) : 32'hDEAD, 32'(i % 2));
            check($sformatf("cont_id%0d", i), (i < iq.size()) ? 32'(iq[i]) : 32'hDEAD, 32'(i % 2));
            check($sformatf("cont_res%0d", i), (i < rq.size()) ? 32'(rq[i]) : 32'hDEAD,
                  (i % 2 == 0) ? 32'h011 : 32'h01E);
        end
        for (int c = 0; c < 30 && busy; c++) @(negedge clk);

        // Backpressure: response held for three cycles.
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(0, 3'd0, 9'h005, 9'h006, 4'd0);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_ready[0]) begin got = 1'b1; break; end
        end
        check("bp_grant", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        set_req(1, 3'd3, 9'h0F0, 9'h00F, 4'd0);
        wait_rsp(lat, got);
        check("bp_rsp_seen", 32'(got), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp_res%0d", i), 32'(bus.rsp_result), 32'h00B);
            check($sformatf("bp_id%0d", i), 32'(bus.rsp_id), 32'd0);
            check($sformatf("bp_ready%0d", i), 32'(bus.req_ready), 32'd0);
            check($sformatf("bp_busy%0d", i), 32'(busy), 32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_after_res_kept", 32'(bus.rsp_result), 32'h00B);
        check("bp_after_busy", 32'(busy), 32'd0);
        check("bp_after_grant1", 32'(bus.req_ready), 32'b10);
        @(posedge clk); #1 bus.req_valid = '0;
        wait_rsp(lat, got);
        check("bp_next_seen", 32'(got), 32'd1);
        check("bp_next_id", 32'(bus.rsp_id), 32'd1);
        check("bp_next_res", 32'(bus.rsp_result), 32'h0FF);

        // Reset in the third EXEC cycle of an 8-bit shift.
        do_reset();
        @(posedge clk); #1;
        set_req(0, 3'd5, 9'h001, 9'h000, 4'd8);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_ready[0]) begin got = 1'b1; break; end
        end
        check("rst_grant", 32'(got), 32'd1);
        @(posedge clk); #1 bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        set_req(0, 3'd0, 9'h011, 9'h022, 4'd0);
        set_req(1, 3'd4, 9'h055, 9'h0AA, 4'd0);
        #1;
        check("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_grant0", 32'(bus.req_ready), 32'b01);
        @(posedge clk); #1 bus.req_valid = '0;
        wait_rsp(lat, got);
        check("rst_after_seen", 32'(got), 32'd1);
        check("rst_after_id", 32'(bus.rsp_id), 32'd0);
        check("rst_after_res", 32'(bus.rsp_result), 32'h033);
        check("rst_after_lat", 32'(lat), 32'd2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
